beta_writeback_stage: RTL and testbench
=======================================

Name: beta_writeback_stage

Overview:
- Writeback stage of the beta core; sits directly upstream of the register file and drives its single write port.
- Arbitrates between the ALU result path and the LSU load-return path using valid/ready handshakes.
- Formats load data by size, sign and byte offset, and registers the winning write for one cycle.
- Keeps a pending-load scoreboard that decode uses for RAW hazard stalls.

Parameters:
DataWidth, 32, width of result/load data and of the regfile write data (only 32 supported)
StarveLimit, 4, consecutive ALU-denied cycles after which the ALU gets forced priority (range 1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted this cycle
alu_rd_addr_i  in  5  ALU destination register
alu_result_i  in  DataWidth  ALU result
lsu_valid_i  in  1  load return valid
lsu_ready_o  out  1  load return accepted this cycle
lsu_rd_addr_i  in  5  load destination register
lsu_rdata_i  in  DataWidth  raw aligned memory word
lsu_funct3_i  in  3  load type (RV32I funct3)
lsu_byte_off_i  in  2  address[1:0] of the load
ld_issue_i  in  1  load issued by execute; marks its rd pending
ld_issue_rd_i  in  5  rd of the issued load
busy_o  out  32  pending-load bitmap; bit 0 is always 0
rf_wr_en_o  out  1  regfile write enable (registered)
rf_rd_addr_o  out  5  regfile write address (registered)
rf_rd_wdata_o  out  DataWidth  regfile write data (registered)
ld_err_o  out  1  one-cycle pulse for an illegal or misaligned load return

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - rf_wr_en_o=0, rf_rd_addr_o=0, rf_rd_wdata_o=0.
  - busy_o=0, ld_err_o=0, starve counter=0.
  - Ready outputs are combinational; they are forced to 0 while rst_i=1.
- Arbitration (combinational ready):
  - Default: LSU wins. lsu_ready_o=1; alu_ready_o = !lsu_valid_i.
  - Forced mode (starve counter == StarveLimit): alu_ready_o=1; lsu_ready_o = !alu_valid_i.
- Starve counter:
  - Increments (saturating at StarveLimit) each cycle alu_valid_i=1 and alu_ready_o=0.
  - Clears on any cycle with an ALU accept.
  - Holds otherwise.
- Latency:
  - The accepted transfer appears on the rf_* outputs on the next clock edge (1 cycle).
  - The regfile commits it one edge later.
- Write gating:
  - rf_wr_en_o is registered as (accept && rd != 0 && !err).
  - With no accept, rf_wr_en_o=0 and addr/data hold their previous values.
- Load formatting: b = byte lsu_byte_off_i, h = halfword at offset[1].
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend h; offset 1 or 3 is an error.
  - 010 LW: full word; offset != 0 is an error.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend h; same misalignment rule as LH.
  - Any other funct3 is an error.
  - On error: no write, ld_err_o pulses 1 cycle later, and the busy clear still happens.
- Scoreboard (next-state):
  - An LSU accept with rd != 0 clears busy[rd].
  - ld_issue_i with ld_issue_rd_i != 0 sets busy[ld_issue_rd_i].
  - If set and clear hit the same register in one cycle, set wins (a newer load is pending).
  - A second issue to an already-busy register leaves it set.
- Reset mid-operation: any in-flight write is dropped (rf_wr_en_o=0 after the reset edge) and the scoreboard is cleared.

Decomposition:
- beta_pkg gets:
  - load funct3 localparams (LD_B, LD_H, LD_W, LD_BU, LD_HU).
  - wb_src_e enum (WB_NONE, WB_ALU, WB_LSU).
  - a wb_req_t struct {rd, data}.
- One sub-module, beta_load_formatter: purely combinational funct3/offset/rdata -> data + err. It is reused by the future store-forward path.

Test Plan:
- Sign-extended load: LSU valid, rd=5, funct3=000, off=2, rdata=0x12_80_34_56. Expect rf_wr_en_o=1, addr=5, wdata=0xFFFFFF80 one cycle later.
- Concurrent sources: ALU valid (rd=3, 0xA5) and LSU valid (rd=4, LW 0xDEADBEEF) in the same cycle. Expect lsu_ready_o=1, alu_ready_o=0, the LSU write first, then the ALU write the next cycle.
- ALU starvation: LSU valid every cycle, ALU valid with StarveLimit=4. Expect alu_ready_o=0 for 4 cycles, then alu_ready_o=1 and lsu_ready_o=0 in the 5th, then the counter clears.
- Scoreboard set/clear collision: ld_issue rd=7, then LSU return rd=7 in the same cycle as a new ld_issue rd=7. Expect busy_o[7] to stay 1; a later return alone clears it to 0.
- x0 and errors:
  - ALU rd=0: expect ready=1 and rf_wr_en_o=0.
  - LH at off=1 to rd=9: expect no write, ld_err_o pulse, busy[9] cleared.
- Reset mid-operation: assert rst_i while an accepted write is in the output register with busy_o=0x0000_0080. Expect rf_wr_en_o=0 and busy_o=0 after the edge.

Source files
------------

// File: rtl/beta_pkg.sv
// beta_pkg: shared types and constants for the beta writeback path.
//   LD_*       RV32I load funct3 encodings understood by the load formatter
//   wb_src_e   which source won writeback arbitration this cycle
//   wb_req_t   a regfile write request (destination + data)
package beta_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LSU  = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/beta_writeback_stage_if.sv
// beta_writeback_stage_if: handshake and regfile-write bundle of the
// writeback stage.
//   alu_*  ALU result channel (valid/ready, rd, result)
//   lsu_*  load-return channel (valid/ready, rd, raw word, funct3, byte offset)
//   rf_*   registered regfile write port
// master: the producers / regfile side (drives ALU and LSU channels).
// slave : the writeback stage itself.
interface beta_writeback_stage_if #(
   parameter int DataWidth = 32
);
   logic                 alu_valid_i;
   logic                 alu_ready_o;
   logic [4:0]           alu_rd_addr_i;
   logic [DataWidth-1:0] alu_result_i;

   logic                 lsu_valid_i;
   logic                 lsu_ready_o;
   logic [4:0]           lsu_rd_addr_i;
   logic [DataWidth-1:0] lsu_rdata_i;
   logic [2:0]           lsu_funct3_i;
   logic [1:0]           lsu_byte_off_i;

   logic                 rf_wr_en_o;
   logic [4:0]           rf_rd_addr_o;
   logic [DataWidth-1:0] rf_rd_wdata_o;

   modport master (
      output alu_valid_i, alu_rd_addr_i, alu_result_i,
      output lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
      input  alu_ready_o, lsu_ready_o,
      input  rf_wr_en_o, rf_rd_addr_o, rf_rd_wdata_o
   );

   modport slave (
      input  alu_valid_i, alu_rd_addr_i, alu_result_i,
      input  lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
      output alu_ready_o, lsu_ready_o,
      output rf_wr_en_o, rf_rd_addr_o, rf_rd_wdata_o
   );
endinterface

// File: rtl/beta_load_formatter.sv
// beta_load_formatter: purely combinational load-data formatter.
//   funct3_i    RV32I load type
//   byte_off_i  address[1:0] of the load
//   rdata_i     raw aligned memory word
//   data_o      extracted and sign/zero-extended value
//   err_o       illegal funct3 or misaligned halfword/word access
// Shared with the store-forward path, so it must stay free of state.
module beta_load_formatter
   import beta_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [2:0]           funct3_i,
   input  logic [1:0]           byte_off_i,
   input  logic [DataWidth-1:0] rdata_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 err_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (byte_off_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      // Halfword selection only looks at offset[1]; offset[0] is the
      // misalignment flag checked below.
      half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = '0;
      err_o  = 1'b0;
      case (funct3_i)
         LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_BU: data_o = {24'd0, byte_sel};
         LD_H: begin
            data_o = {{16{half_sel[15]}}, half_sel};
            err_o  = byte_off_i[0];
         end
         LD_HU: begin
            data_o = {16'd0, half_sel};
            err_o  = byte_off_i[0];
         end
         LD_W: begin
            data_o = rdata_i;
            err_o  = (byte_off_i != 2'd0);
         end
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/beta_writeback_stage.sv
// beta_writeback_stage: writeback stage of the beta core.
//   clk_i, rst_i     clock, synchronous active-high reset
//   wb (slave)       ALU / LSU valid-ready channels and registered regfile port
//   ld_issue_i/rd_i  load issued by execute; marks its rd pending
//   busy_o           pending-load bitmap used by decode for RAW stalls
//   ld_err_o         one-cycle pulse for an illegal or misaligned load return
// LSU returns win by default; an ALU result denied StarveLimit cycles in a row
// is given priority for one accept.
module beta_writeback_stage
   import beta_pkg::*;
#(
   parameter int DataWidth   = 32,
   parameter int StarveLimit = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   beta_writeback_stage_if.slave wb,
   input  logic        ld_issue_i,
   input  logic [4:0]  ld_issue_rd_i,
   output logic [31:0] busy_o,
   output logic        ld_err_o
);

   localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

   logic [3:0]  starve_q, starve_d;
   logic        forced;
   logic        alu_ready, lsu_ready;
   logic        alu_acc, lsu_acc;
   wb_src_e     src;
   wb_req_t     req;
   logic        accept;

   logic [DataWidth-1:0] fmt_data;
   logic                 fmt_err;
   logic                 load_err;

   logic                 wr_en_q;
   logic [4:0]           rd_q;
   logic [DataWidth-1:0] wdata_q;
   logic                 err_q;
   logic [31:0]          busy_q, busy_d;

   beta_load_formatter #(.DataWidth(DataWidth)) u_fmt (
      .funct3_i   (wb.lsu_funct3_i),
      .byte_off_i (wb.lsu_byte_off_i),
      .rdata_i    (wb.lsu_rdata_i),
      .data_o     (fmt_data),
      .err_o      (fmt_err)
   );

   // Arbitration. Ready never depends on the other side's ready, only on
   // valids and the starve counter, so there is no combinational loop.
   always_comb begin
      forced    = (starve_q == STARVE_MAX);
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (!rst_i) begin
         if (forced) begin
            alu_ready = 1'b1;
            lsu_ready = !wb.alu_valid_i;
         end else begin
            lsu_ready = 1'b1;
            alu_ready = !wb.lsu_valid_i;
         end
      end
   end

   assign alu_acc = wb.alu_valid_i && alu_ready;
   assign lsu_acc = wb.lsu_valid_i && lsu_ready;

   // The ready equations make the two accepts mutually exclusive.
   always_comb begin
      src = WB_NONE;
      if (lsu_acc)      src = WB_LSU;
      else if (alu_acc) src = WB_ALU;
   end

   always_comb begin
      req      = '0;
      load_err = 1'b0;
      case (src)
         WB_LSU: begin
            req.rd   = wb.lsu_rd_addr_i;
            req.data = fmt_data;
            load_err = fmt_err;
         end
         WB_ALU: begin
            req.rd   = wb.alu_rd_addr_i;
            req.data = wb.alu_result_i;
         end
         default: req = '0;
      endcase
   end

   assign accept = (src != WB_NONE);

   always_comb begin
      starve_d = starve_q;
      if (alu_acc)
         starve_d = '0;
      else if (wb.alu_valid_i && !alu_ready && (starve_q < STARVE_MAX))
         starve_d = starve_q + 4'd1;
   end

   // Clear first, then set, so a new issue to the returning rd stays pending.
   always_comb begin
      busy_d = busy_q;
      if (lsu_acc && (wb.lsu_rd_addr_i != 5'd0))
         busy_d[wb.lsu_rd_addr_i] = 1'b0;
      if (ld_issue_i && (ld_issue_rd_i != 5'd0))
         busy_d[ld_issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_en_q  <= 1'b0;
         rd_q     <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         wr_en_q <= accept && (req.rd != 5'd0) && !load_err;
         // Faulting loads leave the last write's address/data in place.
         if (accept && !load_err) begin
            rd_q    <= req.rd;
            wdata_q <= req.data;
         end
         err_q    <= load_err;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

   assign wb.alu_ready_o   = alu_ready;
   assign wb.lsu_ready_o   = lsu_ready;
   assign wb.rf_wr_en_o    = wr_en_q;
   assign wb.rf_rd_addr_o  = rd_q;
   assign wb.rf_rd_wdata_o = wdata_q;
   assign busy_o           = busy_q;
   assign ld_err_o         = err_q;

endmodule

// File: tb/tb_beta_writeback_stage.sv
module tb_beta_writeback_stage;
   import beta_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        ld_issue_i = 1'b0;
   logic [4:0]  ld_issue_rd_i = '0;
   logic [31:0] busy_o;
   logic        ld_err_o;

   int checks = 0;
   int failures = 0;
   wb_req_t exp_q[$];
   wb_req_t e;

   beta_writeback_stage_if #(.DataWidth(32)) wb_if ();

   beta_writeback_stage #(.DataWidth(32), .StarveLimit(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .wb            (wb_if),
      .ld_issue_i    (ld_issue_i),
      .ld_issue_rd_i (ld_issue_rd_i),
      .busy_o        (busy_o),
      .ld_err_o      (ld_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      wb_if.alu_valid_i    = 1'b0;
      wb_if.alu_rd_addr_i  = '0;
      wb_if.alu_result_i   = '0;
      wb_if.lsu_valid_i    = 1'b0;
      wb_if.lsu_rd_addr_i  = '0;
      wb_if.lsu_rdata_i    = '0;
      wb_if.lsu_funct3_i   = LD_W;
      wb_if.lsu_byte_off_i = '0;
      ld_issue_i           = 1'b0;
      ld_issue_rd_i        = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_i = 1'b1;
      wb_if.alu_valid_i = 1'b1;
      wb_if.lsu_valid_i = 1'b1;
      #1;
      checks++;
      if (wb_if.alu_ready_o !== 1'b0 || wb_if.lsu_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: alu_ready=%b lsu_ready=%b expected 0 0", wb_if.alu_ready_o, wb_if.lsu_ready_o);
      end
      tick();
      tick();
      checks++;
      if (wb_if.rf_wr_en_o !== 1'b0 || wb_if.rf_rd_addr_o !== 5'd0 || wb_if.rf_rd_wdata_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_rf: en=%b addr=%0d data=%h expected 0 0 0", wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o);
      end
      checks++;
      if (busy_o !== 32'd0 || ld_err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy_err: busy=%h err=%b expected 0 0", busy_o, ld_err_o);
      end
      rst_i = 1'b0;
      idle();
   endtask

   task automatic test_sign_load();
      wb_if.lsu_valid_i    = 1'b1;
      wb_if.lsu_rd_addr_i  = 5'd5;
      wb_if.lsu_funct3_i   = LD_B;
      wb_if.lsu_byte_off_i = 2'd2;
      wb_if.lsu_rdata_i    = 32'h1280_3456;
      #1;
      checks++;
      if (wb_if.lsu_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL lb_ready: lsu_ready=%b expected 1", wb_if.lsu_ready_o);
      end
      exp_q.push_back('{rd: 5'd5, data: 32'hFFFF_FF80});
      tick();
      idle();
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL lb_write: scoreboard empty");
      end else begin
         e = exp_q.pop_front();
         if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
            failures++;
            $display("FAIL lb_write: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                     wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
         end
      end
   endtask

   task automatic test_concurrent();
      wb_if.alu_valid_i    = 1'b1;
      wb_if.alu_rd_addr_i  = 5'd3;
      wb_if.alu_result_i   = 32'h0000_00A5;
      wb_if.lsu_valid_i    = 1'b1;
      wb_if.lsu_rd_addr_i  = 5'd4;
      wb_if.lsu_funct3_i   = LD_W;
      wb_if.lsu_byte_off_i = 2'd0;
      wb_if.lsu_rdata_i    = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (wb_if.lsu_ready_o !== 1'b1 || wb_if.alu_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL conc_ready: alu_ready=%b lsu_ready=%b expected 0 1", wb_if.alu_ready_o, wb_if.lsu_ready_o);
      end
      exp_q.push_back('{rd: 5'd4, data: 32'hDEAD_BEEF});
      tick();
      wb_if.lsu_valid_i = 1'b0;
      checks++;
      e = exp_q.pop_front();
      if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
         failures++;
         $display("FAIL conc_lsu_write: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                  wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
      end
      #1;
      checks++;
      if (wb_if.alu_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL conc_alu_ready: alu_ready=%b expected 1", wb_if.alu_ready_o);
      end
      exp_q.push_back('{rd: 5'd3, data: 32'h0000_00A5});
      tick();
      idle();
      checks++;
      e = exp_q.pop_front();
      if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
         failures++;
         $display("FAIL conc_alu_write: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                  wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
      end
   endtask

   task automatic test_starvation();
      logic exp_alu_rdy;
      for (int i = 0; i < 6; i++) begin
         wb_if.alu_valid_i    = 1'b1;
         wb_if.alu_rd_addr_i  = 5'd10;
         wb_if.alu_result_i   = 32'h0000_0111;
         wb_if.lsu_valid_i    = 1'b1;
         wb_if.lsu_rd_addr_i  = 5'd11;
         wb_if.lsu_funct3_i   = LD_BU;
         wb_if.lsu_byte_off_i = 2'd0;
         wb_if.lsu_rdata_i    = 32'(32'hFFFF_FFA0 + i);
         #1;
         // Four denials, forced ALU win on the fifth, LSU wins again after.
         exp_alu_rdy = (i == 4);
         checks++;
         if (wb_if.alu_ready_o !== exp_alu_rdy || wb_if.lsu_ready_o !== !exp_alu_rdy) begin
            failures++;
            $display("FAIL starve_ready[%0d]: alu_ready=%b lsu_ready=%b expected %b %b",
                     i, wb_if.alu_ready_o, wb_if.lsu_ready_o, exp_alu_rdy, !exp_alu_rdy);
         end
         if (exp_alu_rdy) exp_q.push_back('{rd: 5'd10, data: 32'h0000_0111});
         else             exp_q.push_back('{rd: 5'd11, data: 32'(32'hA0 + i)});
         tick();
         checks++;
         e = exp_q.pop_front();
         if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
            failures++;
            $display("FAIL starve_write[%0d]: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                     i, wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
         end
      end
      idle();
   endtask

   task automatic test_scoreboard();
      ld_issue_i    = 1'b1;
      ld_issue_rd_i = 5'd0;
      tick();
      checks++;
      if (busy_o !== 32'd0) begin
         failures++;
         $display("FAIL busy_x0: busy=%h expected 0", busy_o);
      end
      ld_issue_rd_i = 5'd7;
      tick();
      checks++;
      if (busy_o !== 32'h0000_0080) begin
         failures++;
         $display("FAIL busy_set: busy=%h expected 00000080", busy_o);
      end
      wb_if.lsu_valid_i    = 1'b1;
      wb_if.lsu_rd_addr_i  = 5'd7;
      wb_if.lsu_funct3_i   = LD_W;
      wb_if.lsu_byte_off_i = 2'd0;
      wb_if.lsu_rdata_i    = 32'h0000_0077;
      exp_q.push_back('{rd: 5'd7, data: 32'h0000_0077});
      tick();
      ld_issue_i = 1'b0;
      wb_if.lsu_rdata_i = 32'h0000_0078;
      exp_q.push_back('{rd: 5'd7, data: 32'h0000_0078});
      checks++;
      if (busy_o !== 32'h0000_0080) begin
         failures++;
         $display("FAIL busy_collision: busy=%h expected 00000080", busy_o);
      end
      checks++;
      e = exp_q.pop_front();
      if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
         failures++;
         $display("FAIL sb_write1: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                  wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
      end
      tick();
      idle();
      checks++;
      if (busy_o !== 32'd0) begin
         failures++;
         $display("FAIL busy_clear: busy=%h expected 0", busy_o);
      end
      checks++;
      e = exp_q.pop_front();
      if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data) begin
         failures++;
         $display("FAIL sb_write2: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                  wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, e.rd, e.data);
      end
   endtask

   task automatic test_x0_err();
      wb_if.alu_valid_i   = 1'b1;
      wb_if.alu_rd_addr_i = 5'd0;
      wb_if.alu_result_i  = 32'h0000_0055;
      #1;
      checks++;
      if (wb_if.alu_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL x0_ready: alu_ready=%b expected 1", wb_if.alu_ready_o);
      end
      tick();
      idle();
      checks++;
      if (wb_if.rf_wr_en_o !== 1'b0) begin
         failures++;
         $display("FAIL x0_write: en=%b expected 0", wb_if.rf_wr_en_o);
      end
      ld_issue_i    = 1'b1;
      ld_issue_rd_i = 5'd9;
      tick();
      idle();
      wb_if.lsu_valid_i    = 1'b1;
      wb_if.lsu_rd_addr_i  = 5'd9;
      wb_if.lsu_funct3_i   = LD_H;
      wb_if.lsu_byte_off_i = 2'd1;
      wb_if.lsu_rdata_i    = 32'h1234_5678;
      tick();
      idle();
      checks++;
      if (wb_if.rf_wr_en_o !== 1'b0 || ld_err_o !== 1'b1 || busy_o[9] !== 1'b0) begin
         failures++;
         $display("FAIL lh_misaligned: en=%b err=%b busy9=%b expected 0 1 0", wb_if.rf_wr_en_o, ld_err_o, busy_o[9]);
      end
      tick();
      checks++;
      if (ld_err_o !== 1'b0) begin
         failures++;
         $display("FAIL err_pulse: err=%b expected 0", ld_err_o);
      end
   endtask

   task automatic test_reset_mid();
      ld_issue_i    = 1'b1;
      ld_issue_rd_i = 5'd7;
      wb_if.alu_valid_i   = 1'b1;
      wb_if.alu_rd_addr_i = 5'd12;
      wb_if.alu_result_i  = 32'h0000_1234;
      exp_q.push_back('{rd: 5'd12, data: 32'h0000_1234});
      tick();
      ld_issue_i = 1'b0;
      checks++;
      e = exp_q.pop_front();
      if (wb_if.rf_wr_en_o !== 1'b1 || wb_if.rf_rd_addr_o !== e.rd || wb_if.rf_rd_wdata_o !== e.data || busy_o !== 32'h0000_0080) begin
         failures++;
         $display("FAIL pre_reset: en=%b addr=%0d data=%h busy=%h expected en=1 addr=%0d data=%h busy=00000080",
                  wb_if.rf_wr_en_o, wb_if.rf_rd_addr_o, wb_if.rf_rd_wdata_o, busy_o, e.rd, e.data);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if (wb_if.alu_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_ready: alu_ready=%b expected 0", wb_if.alu_ready_o);
      end
      tick();
      checks++;
      if (wb_if.rf_wr_en_o !== 1'b0 || busy_o !== 32'd0 || wb_if.rf_rd_addr_o !== 5'd0) begin
         failures++;
         $display("FAIL mid_reset: en=%b busy=%h addr=%0d expected 0 0 0", wb_if.rf_wr_en_o, busy_o, wb_if.rf_rd_addr_o);
      end
      rst_i = 1'b0;
      idle();
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_sign_load();
      test_concurrent();
      test_starvation();
      test_scoreboard();
      test_x0_err();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
